// File: rtl/pcs_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pcs_tx_encoder
// Function : 64b/66b transmit encoder. Packs XGMII beats into 8-lane blocks,
//            classifies them (C/S/D/T/E) and emits 66b blocks one cycle later.
// Revision : 1.0
// ============================================================================
module pcs_tx_encoder #(
    parameter int DATA_WIDTH    = 64,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic [DATA_WIDTH-1:0]    i_txd,
    input  logic [DATA_WIDTH/8-1:0]  i_txc,
    output logic                     o_valid,
    output logic [1:0]               o_header,
    output logic [63:0]              o_data,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

    localparam logic [1:0]  C_HDR_DATA = 2'b10;
    localparam logic [1:0]  C_HDR_CTRL = 2'b01;
    localparam logic [63:0] C_E_BLOCK  = {{8{7'h1E}}, 8'h1E};

    localparam logic [2:0]  C_BT_C = 3'd0;
    localparam logic [2:0]  C_BT_S = 3'd1;
    localparam logic [2:0]  C_BT_D = 3'd2;
    localparam logic [2:0]  C_BT_T = 3'd3;
    localparam logic [2:0]  C_BT_E = 3'd4;

    typedef enum logic [2:0] {
        TX_INIT = 3'd0,
        TX_C    = 3'd1,
        TX_D    = 3'd2,
        TX_T    = 3'd3,
        TX_E    = 3'd4
    } tx_state_t;

    // {valid, 7-bit block code} for an XGMII control character
    function automatic logic [7:0] ctrl_code(input logic [7:0] b);
        case (b)
            8'h07:   ctrl_code = {1'b1, 7'h00};
            8'h06:   ctrl_code = {1'b1, 7'h06};
            8'hFE:   ctrl_code = {1'b1, 7'h1E};
            8'h1C:   ctrl_code = {1'b1, 7'h2D};
            8'h3C:   ctrl_code = {1'b1, 7'h33};
            8'h7C:   ctrl_code = {1'b1, 7'h4B};
            8'hBC:   ctrl_code = {1'b1, 7'h55};
            8'hDC:   ctrl_code = {1'b1, 7'h66};
            8'hF7:   ctrl_code = {1'b1, 7'h78};
            default: ctrl_code = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] t_type(input logic [2:0] k);
        case (k)
            3'd0:    t_type = 8'h87;
            3'd1:    t_type = 8'h99;
            3'd2:    t_type = 8'hAA;
            3'd3:    t_type = 8'hB4;
            3'd4:    t_type = 8'hCC;
            3'd5:    t_type = 8'hD2;
            3'd6:    t_type = 8'hE1;
            default: t_type = 8'hFF;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Beat assembly into a full 8-lane block
    // ------------------------------------------------------------------
    logic        w_blk_valid;
    logic [63:0] w_txd;
    logic [7:0]  w_txc;

    generate
        if (DATA_WIDTH == 64) begin : g_w64
            assign w_blk_valid = i_valid;
            assign w_txd       = i_txd;
            assign w_txc       = i_txc;
        end else if (DATA_WIDTH == 32) begin : g_w32
            logic        r_phase;
            logic [31:0] r_lo_txd;
            logic [3:0]  r_lo_txc;

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_phase  <= 1'b0;
                    r_lo_txd <= '0;
                    r_lo_txc <= '0;
                end else if (i_valid) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_lo_txd <= i_txd;
                        r_lo_txc <= i_txc;
                    end
                end
            end

            assign w_blk_valid = i_valid & r_phase;
            assign w_txd       = {i_txd, r_lo_txd};
            assign w_txc       = {i_txc, r_lo_txc};
        end else begin : g_bad_width
            $error("pcs_tx_encoder: DATA_WIDTH must be 32 or 64");
            assign w_blk_valid = 1'b0;
            assign w_txd       = '0;
            assign w_txc       = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lane decode
    // ------------------------------------------------------------------
    logic [7:0] w_code_ok;
    logic [6:0] w_code [8];

    always_comb begin
        logic [7:0] cc;
        for (int i = 0; i < 8; i++) begin
            cc           = ctrl_code(w_txd[8*i +: 8]);
            w_code_ok[i] = w_txc[i] & cc[7];
            w_code[i]    = cc[6:0];
        end
    end

    logic       w_is_d;
    logic       w_is_c;
    logic       w_is_o0;
    logic       w_is_s0;
    logic       w_is_s4;
    logic       w_t_hit;
    logic [2:0] w_t_lane;

    assign w_is_d  = (w_txc == 8'h00);
    assign w_is_c  = &w_code_ok;
    assign w_is_o0 = (w_txc == 8'hF1) &&
                     ((w_txd[7:0] == 8'h9C) || (w_txd[7:0] == 8'h5C)) &&
                     (w_txd[63:32] == 32'h0707_0707);
    assign w_is_s0 = (w_txc == 8'h01) && (w_txd[7:0] == 8'hFB);
    assign w_is_s4 = (w_txc[7:4] == 4'b0001) && (w_txd[39:32] == 8'hFB) &&
                     (&w_code_ok[3:0]);

    // Terminate: lanes below k are data, lane k is FD, lanes above are control
    always_comb begin
        w_t_hit  = 1'b0;
        w_t_lane = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!w_t_hit && (w_txc == (8'hFF << k)) && (w_txd[8*k +: 8] == 8'hFD)) begin
                w_t_hit  = 1'b1;
                w_t_lane = 3'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // Block encoding for the classified type
    // ------------------------------------------------------------------
    logic [2:0]  w_kind;
    logic [1:0]  w_enc_hdr;
    logic [63:0] w_enc_data;

    always_comb begin
        w_kind     = C_BT_E;
        w_enc_hdr  = C_HDR_CTRL;
        w_enc_data = C_E_BLOCK;
        if (w_is_d) begin
            w_kind     = C_BT_D;
            w_enc_hdr  = C_HDR_DATA;
            w_enc_data = w_txd;
        end else if (w_is_c) begin
            w_kind          = C_BT_C;
            w_enc_data      = '0;
            w_enc_data[7:0] = 8'h1E;
            for (int i = 0; i < 8; i++) begin
                w_enc_data[8 + 7*i +: 7] = w_code[i];
            end
        end else if (w_is_o0) begin
            w_kind     = C_BT_C;
            w_enc_data = {28'h0, (w_txd[7:0] == 8'h5C) ? 4'hF : 4'h0,
                          w_txd[31:8], 8'h4B};
        end else if (w_is_s0) begin
            w_kind     = C_BT_S;
            w_enc_data = {w_txd[63:8], 8'h78};
        end else if (w_is_s4) begin
            w_kind     = C_BT_S;
            w_enc_data = {w_txd[63:40], 4'h0, w_code[3], w_code[2],
                          w_code[1], w_code[0], 8'h33};
        end else if (w_t_hit) begin
            w_kind          = C_BT_T;
            w_enc_data      = '0;
            w_enc_data[7:0] = t_type(w_t_lane);
            for (int j = 0; j < 7; j++) begin
                if (3'(j) < w_t_lane) begin
                    w_enc_data[8 + 8*j +: 8] = w_txd[8*j +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit state machine and registered outputs
    // ------------------------------------------------------------------
    tx_state_t              r_state;
    logic                   r_valid;
    logic [1:0]             r_header;
    logic [63:0]            r_data;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    logic      w_accept;
    tx_state_t w_next;

    always_comb begin
        case (r_state)
            TX_INIT, TX_C, TX_T: w_accept = (w_kind == C_BT_C) || (w_kind == C_BT_S);
            TX_D:                w_accept = (w_kind == C_BT_D) || (w_kind == C_BT_T);
            TX_E:                w_accept = (w_kind == C_BT_C) || (w_kind == C_BT_D) ||
                                            (w_kind == C_BT_T);
            default:             w_accept = 1'b0;
        endcase
        case (w_kind)
            C_BT_C:  w_next = TX_C;
            C_BT_S:  w_next = TX_D;
            C_BT_D:  w_next = TX_D;
            C_BT_T:  w_next = TX_T;
            default: w_next = TX_E;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= TX_INIT;
            r_valid     <= 1'b0;
            r_header    <= 2'b00;
            r_data      <= '0;
            r_err_count <= '0;
        end else begin
            r_valid <= w_blk_valid;
            if (w_blk_valid) begin
                if (w_accept) begin
                    r_header <= w_enc_hdr;
                    r_data   <= w_enc_data;
                    r_state  <= w_next;
                end else begin
                    r_header <= C_HDR_CTRL;
                    r_data   <= C_E_BLOCK;
                    r_state  <= TX_E;
                    if (r_err_count != '1) begin
                        r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_header    = r_header;
    assign o_data      = r_data;
    assign o_err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_encoder.sv
`default_nettype none
// Scoreboard bench for pcs_tx_encoder: a 64-bit and a 32-bit instance, each
// checked against a lane-rule reference model of the 64b/66b block encoder.
module tb_pcs_tx_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam int K_C = 0, K_S = 1, K_D = 2, K_T = 3, K_E = 4;
    localparam int S_INIT = 0, S_C = 1, S_D = 2, S_T = 3, S_E = 4;

    // 64-bit instance
    logic        rst64 = 1'b1, v64 = 1'b0;
    logic [63:0] txd64 = '0;
    logic [7:0]  txc64 = '0;
    logic        ov64;
    logic [1:0]  oh64;
    logic [63:0] od64;
    logic [15:0] oe64;

    // 32-bit instance with a 4-bit error counter
    logic        rst32 = 1'b1, v32 = 1'b0;
    logic [31:0] txd32 = '0;
    logic [3:0]  txc32 = '0;
    logic        ov32;
    logic [1:0]  oh32;
    logic [63:0] od32;
    logic [3:0]  oe32;

    pcs_tx_encoder #(.DATA_WIDTH(64), .ERR_CNT_WIDTH(16)) u_dut64 (
        .i_clk(clk), .i_reset(rst64), .i_valid(v64), .i_txd(txd64), .i_txc(txc64),
        .o_valid(ov64), .o_header(oh64), .o_data(od64), .o_err_count(oe64)
    );

    pcs_tx_encoder #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(4)) u_dut32 (
        .i_clk(clk), .i_reset(rst32), .i_valid(v32), .i_txd(txd32), .i_txc(txc32),
        .o_valid(ov32), .o_header(oh32), .o_data(od32), .o_err_count(oe32)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  h;
        logic [63:0] d;
        int          err;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];
    int st64 = S_INIT, st32 = S_INIT;
    int err64 = 0, err32 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int cmap(input logic [7:0] b);
        case (b)
            8'h07: return 'h00;
            8'h06: return 'h06;
            8'hFE: return 'h1E;
            8'h1C: return 'h2D;
            8'h3C: return 'h33;
            8'h7C: return 'h4B;
            8'hBC: return 'h55;
            8'hDC: return 'h66;
            8'hF7: return 'h78;
            default: return -1;
        endcase
    endfunction

    function automatic logic [63:0] e_word();
        logic [63:0] o;
        o = 64'h1E;
        for (int i = 0; i < 8; i++) o[8 + 7*i +: 7] = 7'h1E;
        return o;
    endfunction

    function automatic void ref_encode(input logic [63:0] d, input logic [7:0] c,
                                       output int kind, output logic [1:0] h,
                                       output logic [63:0] o);
        logic [7:0] L [8];
        logic [7:0] ttype [8];
        int n_ctl, n_ok, t_lane;
        bit t_ok, lo_ok;
        ttype = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        n_ctl = 0; n_ok = 0; lo_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            L[i] = d[8*i +: 8];
            if (c[i]) n_ctl++;
            if (c[i] && cmap(L[i]) >= 0) n_ok++;
            if (i < 4 && !(c[i] && cmap(L[i]) >= 0)) lo_ok = 1'b0;
        end
        t_lane = -1;
        for (int k = 0; k < 8; k++) begin
            if (t_lane < 0 && c[k] && L[k] == 8'hFD) begin
                t_ok = 1'b1;
                for (int j = 0; j < 8; j++) begin
                    if (j < k && c[j]) t_ok = 1'b0;
                    if (j > k && !c[j]) t_ok = 1'b0;
                end
                if (t_ok) t_lane = k;
            end
        end
        kind = K_E; h = 2'b01; o = e_word();
        if (n_ctl == 0) begin
            kind = K_D; h = 2'b10; o = d;
        end else if (n_ok == 8) begin
            kind = K_C; o = 64'h1E;
            for (int i = 0; i < 8; i++) o[8 + 7*i +: 7] = 7'(cmap(L[i]));
        end else if (c == 8'hF1 && (L[0] == 8'h9C || L[0] == 8'h5C) &&
                     L[4] == 8'h07 && L[5] == 8'h07 && L[6] == 8'h07 && L[7] == 8'h07) begin
            kind = K_C;
            o = {28'h0, (L[0] == 8'h5C) ? 4'hF : 4'h0, L[3], L[2], L[1], 8'h4B};
        end else if (c == 8'h01 && L[0] == 8'hFB) begin
            kind = K_S; o = {d[63:8], 8'h78};
        end else if (lo_ok && c[4] && L[4] == 8'hFB && c[7:5] == 3'b000) begin
            kind = K_S;
            o = {L[7], L[6], L[5], 4'h0, 7'(cmap(L[3])), 7'(cmap(L[2])),
                 7'(cmap(L[1])), 7'(cmap(L[0])), 8'h33};
        end else if (t_lane >= 0) begin
            kind = K_T; o = 64'(ttype[t_lane]);
            for (int j = 0; j < t_lane; j++) o[8 + 8*j +: 8] = L[j];
        end
    endfunction

    function automatic bit ref_step(input int kind, inout int st);
        bit ok;
        case (st)
            S_D:     ok = (kind == K_D || kind == K_T);
            S_E:     ok = (kind == K_C || kind == K_D || kind == K_T);
            default: ok = (kind == K_C || kind == K_S);
        endcase
        if (!ok) st = S_E;
        else if (kind == K_C) st = S_C;
        else if (kind == K_T) st = S_T;
        else st = S_D;
        return ok;
    endfunction

    function automatic exp_t predict(input logic [63:0] d, input logic [7:0] c,
                                     inout int st, inout int err, input int err_max);
        exp_t e;
        int kind;
        ref_encode(d, c, kind, e.h, e.d);
        if (!ref_step(kind, st)) begin
            e.h = 2'b01; e.d = e_word();
            if (err < err_max) err++;
        end
        e.err = err;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic beat64(input logic [63:0] d, input logic [7:0] c,
                          input bit directed = 1'b0, input logic [1:0] eh = 2'b00,
                          input logic [63:0] ed = 64'h0);
        exp_t e;
        @(negedge clk);
        v64 = 1'b1; txd64 = d; txc64 = c;
        e = predict(d, c, st64, err64, 65535);
        if (directed) begin e.h = eh; e.d = ed; end
        e.cyc = cyc + 1;
        q64.push_back(e);
    endtask

    task automatic idle64(input int n);
        repeat (n) begin @(negedge clk); v64 = 1'b0; end
    endtask

    task automatic block32(input logic [63:0] d, input logic [7:0] c, input int gap,
                           input bit directed = 1'b0, input logic [1:0] eh = 2'b00,
                           input logic [63:0] ed = 64'h0);
        exp_t e;
        @(negedge clk);
        v32 = 1'b1; txd32 = d[31:0]; txc32 = c[3:0];
        repeat (gap) begin @(negedge clk); v32 = 1'b0; end
        @(negedge clk);
        v32 = 1'b1; txd32 = d[63:32]; txc32 = c[7:4];
        e = predict(d, c, st32, err32, 15);
        if (directed) begin e.h = eh; e.d = ed; end
        e.cyc = cyc + 1;
        q32.push_back(e);
    endtask

    task automatic idle32(input int n);
        repeat (n) begin @(negedge clk); v32 = 1'b0; end
    endtask

    // Reset with a beat presented alongside it; that beat must be dropped.
    task automatic reset64();
        @(negedge clk);
        rst64 = 1'b1; v64 = 1'b1; txd64 = {$urandom, $urandom}; txc64 = 8'h00;
        @(negedge clk); v64 = 1'b0;
        repeat (2) @(negedge clk);
        rst64 = 1'b0; st64 = S_INIT; err64 = 0;
        chk("dut64 reset o_valid", 64'(ov64), 64'h0);
        chk("dut64 reset o_header", 64'(oh64), 64'h0);
        chk("dut64 reset o_data", od64, 64'h0);
        chk("dut64 reset o_err_count", 64'(oe64), 64'h0);
    endtask

    task automatic reset32();
        @(negedge clk);
        rst32 = 1'b1; v32 = 1'b1; txd32 = 32'h0707_0707; txc32 = 4'hF;
        @(negedge clk); v32 = 1'b0;
        repeat (2) @(negedge clk);
        rst32 = 1'b0; st32 = S_INIT; err32 = 0;
        chk("dut32 reset o_valid", 64'(ov32), 64'h0);
        chk("dut32 reset o_header", 64'(oh32), 64'h0);
        chk("dut32 reset o_data", od32, 64'h0);
        chk("dut32 reset o_err_count", 64'(oe32), 64'h0);
    endtask

    function automatic void rand_block(output logic [63:0] d, output logic [7:0] c);
        logic [7:0] codes [9];
        int k;
        codes = '{8'h07, 8'h06, 8'hFE, 8'h1C, 8'h3C, 8'h7C, 8'hBC, 8'hDC, 8'hF7};
        d = {$urandom, $urandom};
        c = 8'h00;
        case ($urandom_range(0, 10))
            0: begin d = 64'h0707070707070707; c = 8'hFF; end
            1: begin c = 8'hFF; for (int i = 0; i < 8; i++) d[8*i +: 8] = codes[$urandom_range(0, 8)]; end
            2: begin c = 8'hF1; d[63:32] = 32'h07070707; d[7:0] = $urandom_range(0, 1) ? 8'h9C : 8'h5C; end
            3, 4: begin c = 8'h01; d[7:0] = 8'hFB; end
            5: begin
                c = 8'h1F; d[39:32] = 8'hFB;
                for (int i = 0; i < 4; i++) d[8*i +: 8] = codes[$urandom_range(0, 8)];
            end
            6, 7: c = 8'h00;
            8, 9: begin
                k = $urandom_range(0, 7);
                c = 8'hFF << k; d[8*k +: 8] = 8'hFD;
                for (int j = k + 1; j < 8; j++) d[8*j +: 8] = codes[$urandom_range(0, 8)];
            end
            default: c = 8'($urandom);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    always begin
        exp_t e;
        @(posedge clk); #1;
        if (ov64) begin
            if (q64.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut64 unexpected block: header %b data %h", oh64, od64);
            end else begin
                e = q64.pop_front();
                chk("dut64 block cycle", 64'(cyc), 64'(e.cyc));
                chk("dut64 o_header", 64'(oh64), 64'(e.h));
                chk("dut64 o_data", od64, e.d);
                chk("dut64 o_err_count", 64'(oe64), 64'(e.err));
            end
        end else if (q64.size() > 0 && q64[0].cyc <= cyc) begin
            n_cmp++; n_fail++;
            $display("FAIL dut64 missing block: o_valid 0, expected block at cycle %0d", q64[0].cyc);
            void'(q64.pop_front());
        end
    end

    always begin
        exp_t e;
        @(posedge clk); #1;
        if (ov32) begin
            if (q32.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut32 unexpected block: header %b data %h", oh32, od32);
            end else begin
                e = q32.pop_front();
                chk("dut32 block cycle", 64'(cyc), 64'(e.cyc));
                chk("dut32 o_header", 64'(oh32), 64'(e.h));
                chk("dut32 o_data", od32, e.d);
                chk("dut32 o_err_count", 64'(oe32), 64'(e.err));
            end
        end else if (q32.size() > 0 && q32[0].cyc <= cyc) begin
            n_cmp++; n_fail++;
            $display("FAIL dut32 missing block: o_valid 0, expected block at cycle %0d", q32[0].cyc);
            void'(q32.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [63:0] d;
        logic [7:0]  c;

        reset64();
        beat64(64'h0707070707070707, 8'hFF, 1'b1, 2'b01, 64'h000000000000001E);
        beat64(64'hD5555555555555FB, 8'h01, 1'b1, 2'b01, 64'hD555555555555578);
        beat64(64'h0123456789ABCDEF, 8'h00, 1'b1, 2'b10, 64'h0123456789ABCDEF);
        beat64(64'h07070707FD030201, 8'hF8, 1'b1, 2'b01, 64'h00000000030201B4);
        beat64(64'h0707070707070707, 8'hFF, 1'b1, 2'b01, 64'h000000000000001E);
        beat64(64'h1122334455667788, 8'h00, 1'b1, 2'b01, 64'h3C78F1E3C78F1E1E);
        beat64(64'h0707070707070707, 8'hFF, 1'b1, 2'b01, 64'h000000000000001E);
        idle64(3);
        reset64();
        for (int n = 0; n < 600; n++) begin
            rand_block(d, c);
            beat64(d, c);
            if ($urandom_range(0, 3) == 0) idle64($urandom_range(1, 2));
        end
        idle64(4);

        reset32();
        block32(64'h55555555555555FB, 8'h01, 0, 1'b1, 2'b01, 64'h5555555555555578);
        idle32(2);
        @(negedge clk);
        v32 = 1'b1; txd32 = 32'h07070707; txc32 = 4'hF;
        reset32();
        idle32(3);
        block32(64'h0707070707070707, 8'hFF, 1, 1'b1, 2'b01, 64'h000000000000001E);
        for (int n = 0; n < 20; n++) block32(64'h0, 8'hFF, 0);
        idle32(3);
        chk("dut32 o_err_count saturated", 64'(oe32), 64'hF);
        reset32();
        for (int n = 0; n < 400; n++) begin
            rand_block(d, c);
            block32(d, c, $urandom_range(0, 3) == 0 ? 1 : 0);
            if ($urandom_range(0, 3) == 0) idle32(1);
        end
        idle32(4);

        chk("dut64 scoreboard drained", 64'(q64.size()), 64'h0);
        chk("dut32 scoreboard drained", 64'(q32.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
